// File: rtl/rv32i_types_pkg.sv
// Shared types for the two-stage RV32I core: the machine word and the
// RAM arbiter states, exposed here so trace and monitor code can decode them.
package rv32i_types_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_EN_W = WORD_W / 8;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [BYTE_EN_W-1:0] byte_en_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    localparam byte_en_t FULL_WORD_BE = '1;

endpackage

// File: rtl/pipeline_ram_arbiter.sv
// Shares the single-ported unified RAM between instruction fetch and data
// access; data has priority, fetch is guaranteed a slot after STARVE_LIMIT data grants.
module pipeline_ram_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     i_ren,
    input  word_t    i_addr,
    output word_t    i_rdata,
    output logic     i_busy,
    input  logic     d_ren,
    input  logic     d_wen,
    input  word_t    d_addr,
    input  word_t    d_wdata,
    input  byte_en_t d_byte_en,
    output word_t    d_rdata,
    output logic     d_busy,
    output logic     m_ren,
    output logic     m_wen,
    output word_t    m_addr,
    output word_t    m_wdata,
    output byte_en_t m_byte_en,
    input  word_t    m_rdata,
    input  logic     m_busy
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t state;
    arb_state_t next_state;
    logic [3:0] starve_cnt;

    logic d_req;
    logic d_same_type;
    logic i_ack;
    logic d_ack;
    logic i_elig;
    logic d_elig;
    logic arbitrate;

    // An ack needs the requester to still want exactly what was latched;
    // anything else (flush, redirect, changed type) is silently discarded.
    always_comb begin
        d_req       = d_ren | d_wen;
        d_same_type = m_wen ? d_wen : (d_ren & ~d_wen);
        i_ack       = (state == GRANT_I) && !m_busy && i_ren && (i_addr == m_addr);
        d_ack       = (state == GRANT_D) && !m_busy && d_same_type && (d_addr == m_addr);
        i_elig      = i_ren & ~i_ack;
        d_elig      = d_req & ~d_ack;
        arbitrate   = (state == IDLE) || !m_busy;

        next_state = state;
        if (arbitrate) begin
            if (i_elig && (!d_elig || starve_cnt == STARVE_MAX)) begin
                next_state = GRANT_I;
            end else if (d_elig) begin
                next_state = GRANT_D;
            end else begin
                next_state = IDLE;
            end
        end

        i_busy  = ~i_ack;
        d_busy  = ~d_ack;
        i_rdata = i_ack ? m_rdata : '0;
        d_rdata = d_ack ? m_rdata : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_ren      <= 1'b0;
            m_wen      <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_byte_en  <= '0;
        end else begin
            state <= next_state;

            // Request fields change only when a grant begins or ends.
            if (arbitrate) begin
                case (next_state)
                    GRANT_I: begin
                        m_ren     <= 1'b1;
                        m_wen     <= 1'b0;
                        m_addr    <= i_addr;
                        m_wdata   <= '0;
                        m_byte_en <= FULL_WORD_BE;
                    end
                    GRANT_D: begin
                        m_ren     <= ~d_wen;
                        m_wen     <= d_wen;
                        m_addr    <= d_addr;
                        m_wdata   <= d_wdata;
                        m_byte_en <= d_byte_en;
                    end
                    default: begin
                        m_ren     <= 1'b0;
                        m_wen     <= 1'b0;
                        m_addr    <= '0;
                        m_wdata   <= '0;
                        m_byte_en <= '0;
                    end
                endcase
            end

            if (!i_ren || (arbitrate && next_state == GRANT_I)) begin
                starve_cnt <= '0;
            end else if (arbitrate && next_state == GRANT_D && starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ram_arbiter.sv
// Scoreboard bench for pipeline_ram_arbiter: directed requests push expected
// grants and acks; a negedge monitor pops and compares whatever the DUT presents.
module tb_pipeline_ram_arbiter;
    import rv32i_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST;
    logic     i_ren;
    word_t    i_addr;
    word_t    i_rdata;
    logic     i_busy;
    logic     d_ren;
    logic     d_wen;
    word_t    d_addr;
    word_t    d_wdata;
    byte_en_t d_byte_en;
    word_t    d_rdata;
    logic     d_busy;
    logic     m_ren;
    logic     m_wen;
    word_t    m_addr;
    word_t    m_wdata;
    byte_en_t m_byte_en;
    word_t    m_rdata;
    logic     m_busy;

    pipeline_ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_busy(d_busy),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byte_en(m_byte_en), .m_rdata(m_rdata), .m_busy(m_busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic word_t ram_data(word_t a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    // RAM model: each access holds m_busy high for ram_lat cycles.
    int ram_lat = 0;
    int age = 0;
    assign m_busy  = (m_ren | m_wen) && (age < ram_lat);
    assign m_rdata = ram_data(m_addr);
    always @(posedge CLK) begin
        if ((m_ren | m_wen) && m_busy) age <= age + 1;
        else age <= 0;
    end

    typedef struct {
        int       cyc;
        logic     ren;
        logic     wen;
        word_t    addr;
        word_t    wdata;
        byte_en_t be;
        bit       chk_data;
    } grant_t;

    typedef struct {
        int    cyc;
        word_t rdata;
    } ack_t;

    grant_t grant_q[$];
    ack_t   iack_q[$];
    ack_t   dack_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check_output(string name, word_t got, word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_grant(int c, logic r, logic w, word_t a, word_t wd, byte_en_t be, bit chk);
        grant_t g;
        g.cyc = c; g.ren = r; g.wen = w; g.addr = a; g.wdata = wd; g.be = be; g.chk_data = chk;
        grant_q.push_back(g);
    endtask

    task automatic push_ack(bit is_data, int c, word_t rd);
        ack_t a;
        a.cyc = c; a.rdata = rd;
        if (is_data) dack_q.push_back(a);
        else iack_q.push_back(a);
    endtask

    task automatic apply_stimulus(logic ir, word_t ia, logic dr, logic dw, word_t da, word_t dwd, byte_en_t be);
        i_ren = ir; i_addr = ia;
        d_ren = dr; d_wen = dw; d_addr = da; d_wdata = dwd; d_byte_en = be;
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: a grant is new when strobes appear after idle or after a completion.
    bit     prev_granted = 1'b0;
    bit     prev_done = 1'b0;
    logic   granted;
    grant_t mg;
    ack_t   ma;
    always @(negedge CLK) begin
        granted = m_ren | m_wen;
        if (granted && (!prev_granted || prev_done)) begin
            checks++;
            if (grant_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL grant: got unexpected grant addr 0x%08h at cycle %0d, expected none", m_addr, cyc);
            end else begin
                mg = grant_q.pop_front();
                if (cyc != mg.cyc || m_ren !== mg.ren || m_wen !== mg.wen || m_addr !== mg.addr ||
                    (mg.chk_data && (m_wdata !== mg.wdata || m_byte_en !== mg.be))) begin
                    errors++;
                    $display("[TB] FAIL grant: got cyc %0d ren %b wen %b addr 0x%08h wdata 0x%08h be %h, expected cyc %0d ren %b wen %b addr 0x%08h wdata 0x%08h be %h",
                             cyc, m_ren, m_wen, m_addr, m_wdata, m_byte_en,
                             mg.cyc, mg.ren, mg.wen, mg.addr, mg.wdata, mg.be);
                end
            end
        end
        prev_granted = granted;
        prev_done    = granted && !m_busy;

        if (i_busy === 1'b0) begin
            checks++;
            if (iack_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL i_ack: got unexpected ack at cycle %0d, expected none", cyc);
            end else begin
                ma = iack_q.pop_front();
                if (cyc != ma.cyc || i_rdata !== ma.rdata) begin
                    errors++;
                    $display("[TB] FAIL i_ack: got cyc %0d rdata 0x%08h, expected cyc %0d rdata 0x%08h", cyc, i_rdata, ma.cyc, ma.rdata);
                end
            end
        end else begin
            check_output("i_rdata_idle", i_rdata, 32'h0);
        end

        if (d_busy === 1'b0) begin
            checks++;
            if (dack_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL d_ack: got unexpected ack at cycle %0d, expected none", cyc);
            end else begin
                ma = dack_q.pop_front();
                if (cyc != ma.cyc || d_rdata !== ma.rdata) begin
                    errors++;
                    $display("[TB] FAIL d_ack: got cyc %0d rdata 0x%08h, expected cyc %0d rdata 0x%08h", cyc, d_rdata, ma.cyc, ma.rdata);
                end
            end
        end else begin
            check_output("d_rdata_idle", d_rdata, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    int t0;
    initial begin
        nRST = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        step(3);
        nRST = 1'b1;
        @(negedge CLK);
        check_output("rst_m_ren", {31'b0, m_ren}, 32'h0);
        check_output("rst_m_wen", {31'b0, m_wen}, 32'h0);
        check_output("rst_m_addr", m_addr, 32'h0);
        check_output("rst_m_wdata", m_wdata, 32'h0);
        check_output("rst_m_byte_en", {28'b0, m_byte_en}, 32'h0);
        check_output("rst_i_busy", {31'b0, i_busy}, 32'h1);
        check_output("rst_d_busy", {31'b0, d_busy}, 32'h1);
        check_output("rst_starve_cnt", {28'b0, dut.starve_cnt}, 32'h0);
        step(2);

        $display("[TB] lone fetch");
        ram_lat = 0;
        t0 = cyc;
        apply_stimulus(1, 32'h200, 0, 0, 0, 0, 0);
        push_grant(t0 + 1, 1, 0, 32'h200, 0, 0, 0);
        push_ack(0, t0 + 1, ram_data(32'h200));
        step(2);
        i_ren = 1'b0;
        @(negedge CLK);
        check_output("fetch_then_idle", {30'b0, m_ren, m_wen}, 32'h0);
        step(2);

        $display("[TB] contention");
        ram_lat = 2;
        t0 = cyc;
        apply_stimulus(1, 32'h100, 1, 0, 32'h8000, 0, 4'hF);
        push_grant(t0 + 1, 0 + 1'b1, 0, 32'h8000, 0, 4'hF, 1);
        push_ack(1, t0 + 3, ram_data(32'h8000));
        push_grant(t0 + 4, 1, 0, 32'h100, 0, 0, 0);
        push_ack(0, t0 + 6, ram_data(32'h100));
        step(4);
        d_ren = 1'b0;
        step(3);
        i_ren = 1'b0;
        step(2);

        $display("[TB] starvation");
        ram_lat = 0;
        t0 = cyc;
        apply_stimulus(1, 32'h400, 1, 0, 32'h1000, 0, 4'hF);
        for (int k = 0; k < 4; k++) push_grant(t0 + 1 + k, 1, 0, 32'h1000 + 32'(4 * k), 0, 4'hF, 1);
        push_grant(t0 + 5, 1, 0, 32'h400, 0, 0, 0);
        push_ack(0, t0 + 5, ram_data(32'h400));
        push_grant(t0 + 6, 1, 0, 32'h1010, 0, 4'hF, 1);
        push_ack(1, t0 + 6, ram_data(32'h1010));
        for (int k = 1; k <= 4; k++) begin
            step();
            d_addr = 32'h1000 + 32'(4 * k);
            @(negedge CLK);
            check_output("starve_cnt_rise", {28'b0, dut.starve_cnt}, 32'(k));
        end
        step();
        @(negedge CLK);
        check_output("starve_cnt_after_fetch", {28'b0, dut.starve_cnt}, 32'h0);
        step();
        i_ren = 1'b0;
        step();
        d_ren = 1'b0;
        step(2);

        $display("[TB] flush mid-access");
        ram_lat = 2;
        t0 = cyc;
        apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0);
        push_grant(t0 + 1, 1, 0, 32'h100, 0, 0, 0);
        push_grant(t0 + 4, 1, 0, 32'h300, 0, 0, 0);
        push_ack(0, t0 + 6, ram_data(32'h300));
        step();
        i_addr = 32'h300;
        step(2);
        @(negedge CLK);
        check_output("flush_no_ack", {31'b0, i_busy}, 32'h1);
        step(3);
        step();
        i_ren = 1'b0;
        step(2);

        $display("[TB] write with both strobes");
        ram_lat = 1;
        t0 = cyc;
        apply_stimulus(0, 0, 1, 1, 32'h9000, 32'hCAFE_BABE, 4'h3);
        push_grant(t0 + 1, 0, 1, 32'h9000, 32'hCAFE_BABE, 4'h3, 1);
        push_ack(1, t0 + 2, ram_data(32'h9000));
        step(3);
        d_ren = 1'b0;
        d_wen = 1'b0;
        step(2);

        $display("[TB] reset mid-grant");
        ram_lat = 5;
        t0 = cyc;
        apply_stimulus(1, 32'h500, 0, 1, 32'hA000, 32'h1234, 4'hF);
        push_grant(t0 + 1, 0, 1, 32'hA000, 32'h1234, 4'hF, 1);
        step();
        @(negedge CLK);
        check_output("starve_cnt_before_rst", {28'b0, dut.starve_cnt}, 32'h1);
        step();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        check_output("rst_mid_m_wen", {31'b0, m_wen}, 32'h0);
        check_output("rst_mid_m_ren", {31'b0, m_ren}, 32'h0);
        check_output("rst_mid_d_busy", {31'b0, d_busy}, 32'h1);
        check_output("rst_mid_starve_cnt", {28'b0, dut.starve_cnt}, 32'h0);
        step(3);

        check_output("grant_q_drained", 32'(grant_q.size()), 32'h0);
        check_output("iack_q_drained", 32'(iack_q.size()), 32'h0);
        check_output("dack_q_drained", 32'(dack_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
